// File: rtl/run_mon_pkg.sv
// run_mon_pkg
// Shared definitions for the run_monitor program-run controller:
//   - state_t   : controller states IDLE / LOAD / RUN / DONE
//   - DC_*      : done_code values reported when a run ends
package run_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] DC_NONE    = 2'd0;
  localparam logic [1:0] DC_HALT    = 2'd1;
  localparam logic [1:0] DC_TIMEOUT = 2'd2;
  localparam logic [1:0] DC_STALL   = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   in  1  clock
//   rst_n in  1  asynchronous active-low reset (count -> 0)
//   clr   in  1  synchronous clear, wins over en
//   en    in  1  count enable
//   cnt   out W  current count (registered)
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/run_monitor.sv
// run_monitor
// Program-run controller for the RV32IMF core. On start it forces the fetch
// PC to start_pc, then counts RUN cycles and valid-PC cycles until the run
// ends on: a return to HALT_ADDR after the guard window (done_code 1), the
// cycle budget running out (done_code 2), or a stalled PC (done_code 3).
// Priority when several end conditions coincide: halt > stall > timeout.
//
// Optional feature: define RUN_MONITOR_STALL_DET_EN to build the stall
// tracker. Without it done_code 3 never occurs and STALL_LIMIT is unused.
//
// Ports:
//   clk          in  1      core clock
//   rst_n        in  1      asynchronous active-low reset
//   start        in  1      run start pulse (honoured in IDLE/DONE only)
//   start_pc     in  XLEN   PC to load at run start
//   pc           in  XLEN   current fetch-stage PC
//   pc_valid     in  1      pc carries an instruction this cycle
//   pc_load      out 1      one-cycle strobe forcing the fetch PC
//   pc_load_val  out XLEN   latched start_pc
//   running      out 1      high while in RUN
//   done         out 1      high in DONE until the next start
//   done_code    out 2      reason the run ended (DC_*)
//   cycle_cnt    out CNT_W  cycles spent in RUN (saturating)
//   instr_cnt    out CNT_W  pc_valid cycles seen in RUN (saturating)
module run_monitor
  import run_mon_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     CNT_W        = 32,
  parameter logic [XLEN-1:0] HALT_ADDR    = '0,
  parameter int unsigned     GUARD_CYCLES = 20,
  parameter int unsigned     MAX_CYCLES   = 0,
  parameter int unsigned     STALL_LIMIT  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [XLEN-1:0]  start_pc,
  input  logic [XLEN-1:0]  pc,
  input  logic             pc_valid,
  output logic             pc_load,
  output logic [XLEN-1:0]  pc_load_val,
  output logic             running,
  output logic             done,
  output logic [1:0]       done_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [CNT_W-1:0] GUARD_VAL = CNT_W'(GUARD_CYCLES);
  // Compare against the pre-increment count so the run lasts MAX_CYCLES.
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MAX_CYCLES - 1);

  state_t state;

  logic in_run;
  logic start_ok;
  logic halt_hit;
  logic timeout_hit;
  logic stall_hit;

  assign in_run   = (state == RUN);
  assign start_ok = start && ((state == IDLE) || (state == DONE));

  // The guard window lets the core pass through HALT_ADDR right after boot.
  assign halt_hit    = in_run && pc_valid && (pc == HALT_ADDR) && (cycle_cnt >= GUARD_VAL);
  assign timeout_hit = in_run && (MAX_CYCLES != 0) && (cycle_cnt == TIMEOUT_VAL);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_ok),
    .en    (in_run),
    .cnt   (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_ok),
    .en    (in_run && pc_valid),
    .cnt   (instr_cnt)
  );

`ifdef RUN_MONITOR_STALL_DET_EN
  localparam int unsigned     STALL_W   = $clog2(STALL_LIMIT) + 1;
  // Event fires in the cycle whose repeat would bring the tracker to
  // STALL_LIMIT-1, i.e. on the STALL_LIMIT-th identical valid PC.
  localparam logic [STALL_W-1:0] STALL_TGT = STALL_W'(STALL_LIMIT - 2);

  logic [XLEN-1:0]    prev_pc;
  logic               prev_ok;
  logic               same_pc;
  logic [STALL_W-1:0] stall_cnt;

  // A run's first valid PC has nothing to compare against.
  assign same_pc = pc_valid && prev_ok && (pc == prev_pc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_pc <= '0;
      prev_ok <= 1'b0;
    end else if (start_ok) begin
      prev_pc <= '0;
      prev_ok <= 1'b0;
    end else if (in_run && pc_valid) begin
      prev_pc <= pc;
      prev_ok <= 1'b1;
    end
  end

  sat_counter #(.W(STALL_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_ok || (in_run && pc_valid && !same_pc)),
    .en    (in_run && same_pc),
    .cnt   (stall_cnt)
  );

  assign stall_hit = in_run && same_pc && (stall_cnt == STALL_TGT);
`else
  localparam int unsigned unused_stall_limit = STALL_LIMIT;
  assign stall_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc_load     <= 1'b0;
      pc_load_val <= '0;
      running     <= 1'b0;
      done        <= 1'b0;
      done_code   <= DC_NONE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= LOAD;
            pc_load     <= 1'b1;
            pc_load_val <= start_pc;
            done        <= 1'b0;
            done_code   <= DC_NONE;
          end
        end
        LOAD: begin
          state   <= RUN;
          pc_load <= 1'b0;
          running <= 1'b1;
        end
        RUN: begin
          if (halt_hit || stall_hit || timeout_hit) begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
            if (halt_hit) begin
              done_code <= DC_HALT;
            end else if (stall_hit) begin
              done_code <= DC_STALL;
            end else begin
              done_code <= DC_TIMEOUT;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_monitor.sv
module tb_run_monitor;

  logic        clk;
  logic        rst_n;
  logic [2:0]  start;
  logic [31:0] start_pc;
  logic [31:0] pc;
  logic        pc_valid;

  logic        pc_load     [3];
  logic [31:0] pc_load_val [3];
  logic        running     [3];
  logic        done        [3];
  logic [1:0]  done_code   [3];
  logic [31:0] cycle_cnt   [3];
  logic [31:0] instr_cnt   [3];

  int tests;
  int failed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // u_a: no budget; u_b: 100-cycle budget; u_c: 31-cycle budget so its
  // timeout lands on the same cycle as the halt in the halt scenario.
  run_monitor #(.XLEN(32), .CNT_W(32), .HALT_ADDR(32'h0), .GUARD_CYCLES(20),
                .MAX_CYCLES(0), .STALL_LIMIT(16)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .start_pc(start_pc),
    .pc(pc), .pc_valid(pc_valid), .pc_load(pc_load[0]),
    .pc_load_val(pc_load_val[0]), .running(running[0]), .done(done[0]),
    .done_code(done_code[0]), .cycle_cnt(cycle_cnt[0]), .instr_cnt(instr_cnt[0]));

  run_monitor #(.XLEN(32), .CNT_W(32), .HALT_ADDR(32'h0), .GUARD_CYCLES(20),
                .MAX_CYCLES(100), .STALL_LIMIT(16)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .start_pc(start_pc),
    .pc(pc), .pc_valid(pc_valid), .pc_load(pc_load[1]),
    .pc_load_val(pc_load_val[1]), .running(running[1]), .done(done[1]),
    .done_code(done_code[1]), .cycle_cnt(cycle_cnt[1]), .instr_cnt(instr_cnt[1]));

  run_monitor #(.XLEN(32), .CNT_W(32), .HALT_ADDR(32'h0), .GUARD_CYCLES(20),
                .MAX_CYCLES(31), .STALL_LIMIT(16)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .start_pc(start_pc),
    .pc(pc), .pc_valid(pc_valid), .pc_load(pc_load[2]),
    .pc_load_val(pc_load_val[2]), .running(running[2]), .done(done[2]),
    .done_code(done_code[2]), .cycle_cnt(cycle_cnt[2]), .instr_cnt(instr_cnt[2]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, obs);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int loads;
    int early;
    int n;

    tests    = 0;
    failed   = 0;
    rst_n    = 1'b0;
    start    = 3'b000;
    start_pc = 32'h0;
    pc       = 32'h0;
    pc_valid = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) tick();
    check("rst_pc_load",     64'(pc_load[0]),     64'd0);
    check("rst_pc_load_val", 64'(pc_load_val[0]), 64'd0);
    check("rst_running",     64'(running[0]),     64'd0);
    check("rst_done",        64'(done[0]),        64'd0);
    check("rst_done_code",   64'(done_code[0]),   64'd0);
    check("rst_cycle_cnt",   64'(cycle_cnt[0]),   64'd0);
    check("rst_instr_cnt",   64'(instr_cnt[0]),   64'd0);
    rst_n = 1'b1;
    tick();

    // ---------------- halt (u_a) + simultaneous halt/timeout (u_c) ----------------
    start_pc = 32'h0;
    start    = 3'b101;
    tick();                       // LOAD cycle
    start    = 3'b000;
    loads    = int'(pc_load[0]);
    check("halt_load_strobe", 64'(pc_load[0]), 64'd1);
    check("halt_not_running_in_load", 64'(running[0]), 64'd0);
    tick();                       // RUN cycle 0
    loads += int'(pc_load[0]);
    check("halt_running", 64'(running[0]), 64'd1);
    early = 0;
    for (int k = 0; k <= 30; k++) begin
      pc_valid = 1'b1;
      if (k < 4)       pc = 32'h0;
      else if (k < 30) pc = 32'(4 * (k - 3));
      else             pc = 32'h0;
      tick();
      loads += int'(pc_load[0]);
      if (k < 30 && done[0]) early++;
    end
    check("halt_early_done",  64'(early),        64'd0);
    check("halt_pc_load_cnt", 64'(loads),        64'd1);
    check("halt_done",        64'(done[0]),      64'd1);
    check("halt_running_off", 64'(running[0]),   64'd0);
    check("halt_code",        64'(done_code[0]), 64'd1);
    check("halt_cycle_cnt",   64'(cycle_cnt[0]), 64'd31);
    check("halt_instr_cnt",   64'(instr_cnt[0]), 64'd31);
    check("simul_code",       64'(done_code[2]), 64'd1);
    check("simul_cycle_cnt",  64'(cycle_cnt[2]), 64'd31);
    pc_valid = 1'b0;
    tick();
    check("done_freeze_cycle", 64'(cycle_cnt[0]), 64'd31);

    // ---------------- guard window (u_a), rerun-from-DONE timeout (u_c) ----------------
    start_pc = 32'h100;
    start    = 3'b101;
    tick();
    start    = 3'b000;
    check("guard_load_val",  64'(pc_load_val[0]), 64'h100);
    check("guard_done_clr",  64'(done[0]),        64'd0);
    check("guard_code_clr",  64'(done_code[0]),   64'd0);
    check("guard_cycle_clr", 64'(cycle_cnt[0]),   64'd0);
    tick();
    for (int k = 0; k <= 30; k++) begin
      pc_valid = (k < 10);
      pc       = (k == 5) ? 32'h0 : 32'(32'h100 + 4 * k);
      tick();
      if (k == 9) begin
        check("guard_still_running", 64'(running[0]),   64'd1);
        check("guard_no_done",       64'(done[0]),      64'd0);
        check("guard_cycle_cnt",     64'(cycle_cnt[0]), 64'd10);
        check("guard_c_no_done",     64'(done[2]),      64'd0);
      end
    end
    check("c_timeout_done",  64'(done[2]),      64'd1);
    check("c_timeout_code",  64'(done_code[2]), 64'd2);
    check("c_timeout_cycle", 64'(cycle_cnt[2]), 64'd31);
    check("c_timeout_instr", 64'(instr_cnt[2]), 64'd10);
    check("a_instr_invalid", 64'(instr_cnt[0]), 64'd10);

    // ---------------- timeout (u_b) ----------------
    start_pc = 32'h200;
    start    = 3'b010;
    tick();
    start    = 3'b000;
    tick();
    for (int k = 0; k < 100; k++) begin
      pc_valid = 1'b1;
      pc       = 32'(32'h200 + 4 * k);
      tick();
      if (k == 98) check("timeout_not_yet", 64'(done[1]), 64'd0);
    end
    check("timeout_done",  64'(done[1]),      64'd1);
    check("timeout_code",  64'(done_code[1]), 64'd2);
    check("timeout_cycle", 64'(cycle_cnt[1]), 64'd100);
    check("timeout_instr", 64'(instr_cnt[1]), 64'd100);

    // ---------------- asynchronous reset mid-run ----------------
    rst_n = 1'b0;
    #2;
    check("arst_running",   64'(running[0]),     64'd0);
    check("arst_cycle_cnt", 64'(cycle_cnt[0]),   64'd0);
    check("arst_load_val",  64'(pc_load_val[0]), 64'd0);
    check("arst_b_done",    64'(done[1]),        64'd0);
    check("arst_b_code",    64'(done_code[1]),   64'd0);
    check("arst_b_instr",   64'(instr_cnt[1]),   64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---------------- stall (fresh run after reset) ----------------
    start_pc = 32'h40;
    start    = 3'b011;
    tick();
    start    = 3'b000;
    check("stall_load_val", 64'(pc_load_val[0]), 64'h40);
    tick();
    pc       = 32'h40;
    pc_valid = 1'b1;
    n = 0;
    while (!done[1] && n < 120) begin
      tick();
      n++;
    end
    check("stall_wait_bound", 64'(n < 120), 64'd1);
`ifdef RUN_MONITOR_STALL_DET_EN
    check("stall_b_code",  64'(done_code[1]), 64'd3);
    check("stall_b_cycle", 64'(cycle_cnt[1]), 64'd16);
    check("stall_a_done",  64'(done[0]),      64'd1);
    check("stall_a_code",  64'(done_code[0]), 64'd3);
    check("stall_a_cycle", 64'(cycle_cnt[0]), 64'd16);
    check("stall_a_instr", 64'(instr_cnt[0]), 64'd16);
`else
    check("stall_b_code",  64'(done_code[1]), 64'd2);
    check("stall_b_cycle", 64'(cycle_cnt[1]), 64'd100);
    check("stall_a_done",  64'(done[0]),      64'd0);
    check("stall_a_run",   64'(running[0]),   64'd1);
    check("stall_a_cycle", 64'(cycle_cnt[0]), 64'd100);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
